// File: rtl/wb_pkg.sv
// Shared Wishbone interconnect types and SoC default address map.
package wb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } wb_xbar_st_t;

  localparam int WB_AW = 32;
  localparam int WB_DW = 32;
  localparam int WB_NS = 3;

  // Slave 0 (memory) in the LSBs, then DMA registers, then keyboard.
  localparam logic [WB_NS*WB_AW-1:0] WB_SLV_BASE = {32'h0001_0100, 32'h0001_0000, 32'h0000_0000};
  localparam logic [WB_NS*WB_AW-1:0] WB_SLV_MASK = {32'hFFFF_FFF0, 32'hFFFF_FF00, 32'hFFFF_8000};

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester found searching upward from last+1.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);

  int          j;
  logic [IW-1:0] cand;
  logic        found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    cand  = '0;
    for (int k = 1; k <= N; k++) begin
      j    = (int'(last_i) + k) % N;
      cand = IW'(j);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/wb_rr_xbar.sv
// Wishbone-classic shared bus: NM masters, NS slaves, round-robin arbitration,
// base/mask decode, and decode-miss / timeout error reporting on m_err.
module wb_rr_xbar
  import wb_pkg::*;
#(
  parameter int                 NM       = 2,
  parameter int                 NS       = 3,
  parameter int                 AW       = WB_AW,
  parameter int                 DW       = WB_DW,
  parameter logic [NS*AW-1:0]   SLV_BASE = WB_SLV_BASE,
  parameter logic [NS*AW-1:0]   SLV_MASK = WB_SLV_MASK,
  parameter int                 TIMEOUT  = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NM-1:0]        m_cyc,
  input  logic [NM-1:0]        m_we,
  input  logic [NM*(DW/8)-1:0] m_strb,
  input  logic [NM*AW-1:0]     m_addr,
  input  logic [NM*DW-1:0]     m_data_i,
  output logic [NM-1:0]        m_ack,
  output logic [NM-1:0]        m_err,
  output logic [NM*DW-1:0]     m_data_o,
  output logic [NS-1:0]        s_cyc,
  output logic                 s_we,
  output logic [DW/8-1:0]      s_strb,
  output logic [AW-1:0]        s_addr,
  output logic [DW-1:0]        s_data_o,
  input  logic [NS-1:0]        s_ack,
  input  logic [NS*DW-1:0]     s_data_i
);

  localparam int GW = (NM > 1) ? $clog2(NM) : 1;
  localparam int BW = DW / 8;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT);

  wb_xbar_st_t   state_q, state_d;
  logic [GW-1:0] gnt_q, gnt_d;
  logic [GW-1:0] last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [NM-1:0] arb_oh;
  logic [GW-1:0] arb_idx;

  logic [NM-1:0] g_oh;
  logic          g_cyc;
  logic          g_we;
  logic [BW-1:0] g_strb;
  logic [AW-1:0] g_addr;
  logic [DW-1:0] g_wdata;

  logic [NS-1:0] sel_oh;
  logic          hit;
  logic          sel_ack;
  logic [DW-1:0] sel_rdata;
  logic [DW-1:0] rdata;

  rr_arbiter #(.N(NM), .IW(GW)) u_arb (
    .req_i  (m_cyc),
    .last_i (last_q),
    .gnt_o  (arb_oh),
    .idx_o  (arb_idx)
  );

  always_comb begin
    g_oh    = '0;
    g_cyc   = 1'b0;
    g_we    = 1'b0;
    g_strb  = '0;
    g_addr  = '0;
    g_wdata = '0;
    for (int m = 0; m < NM; m++) begin
      if (GW'(m) == gnt_q) begin
        g_oh[m] = 1'b1;
        g_cyc   = m_cyc[m];
        g_we    = m_we[m];
        g_strb  = m_strb[m*BW +: BW];
        g_addr  = m_addr[m*AW +: AW];
        g_wdata = m_data_i[m*DW +: DW];
      end
    end
  end

  // Descending scan so the lowest-indexed matching slave wins overlaps.
  always_comb begin
    sel_oh    = '0;
    hit       = 1'b0;
    for (int s = NS - 1; s >= 0; s--) begin
      if ((g_addr & SLV_MASK[s*AW +: AW]) == SLV_BASE[s*AW +: AW]) begin
        sel_oh    = '0;
        sel_oh[s] = 1'b1;
        hit       = 1'b1;
      end
    end
    sel_ack   = 1'b0;
    sel_rdata = '0;
    for (int s = 0; s < NS; s++) begin
      if (sel_oh[s]) begin
        sel_ack   = s_ack[s];
        sel_rdata = s_data_i[s*DW +: DW];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    s_cyc    = '0;
    s_we     = 1'b0;
    s_strb   = '0;
    s_addr   = '0;
    s_data_o = '0;
    m_ack    = '0;
    m_err    = '0;
    rdata    = '0;
    unique case (state_q)
      IDLE: begin
        if (|arb_oh) begin
          state_d = BUSY;
          gnt_d   = arb_idx;
          last_d  = arb_idx;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        s_we     = g_we;
        s_strb   = g_strb;
        s_addr   = g_addr;
        s_data_o = g_wdata;
        if (hit) rdata = sel_rdata;
        // Priority: master abort, decode miss, timeout, then normal ack.
        if (!g_cyc) begin
          state_d = IDLE;
        end else if (!hit) begin
          m_err   = g_oh;
          state_d = IDLE;
        end else if (cnt_q >= TO_MAX) begin
          m_err   = g_oh;
          state_d = IDLE;
        end else begin
          s_cyc = sel_oh;
          if (sel_ack) begin
            m_ack   = g_oh;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= GW'(NM - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign m_data_o = {NM{rdata}};

endmodule
